// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction-fetch sequencer (optional fetch timeout: FETCH_TIMEOUT_EN)
module pc_fetch_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          INC      = 1,
    parameter int unsigned          TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] in_ALU,
    input  logic              S_MXPC,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              fetch_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    logic [1:0]  state;
    logic [31:0] instr_q;
    // One-cycle request blackout after a redirect so the old address is never confused with the new one
    logic        gap;
    logic        timed_out;

    assign pc_plus     = pc + INC_V;
    assign imem_addr   = pc;
    assign imem_req    = (state == S_FETCH) && !gap;
    assign instr_valid = (state == S_HOLD);
    assign instr_out   = instr_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign fetch_err = err_q;
    assign timed_out = imem_req && !imem_ack && !flush && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != S_FETCH || flush || gap) begin
                wait_cnt <= '0;
            end else if (!imem_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign fetch_err = 1'b0;
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            instr_q <= '0;
            gap     <= 1'b0;
        end else begin
            gap <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        pc <= in_ALU;
                    end else if (en) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (flush) begin
                        pc    <= in_ALU;
                        gap   <= en;
                        state <= en ? S_FETCH : S_IDLE;
                    end else if (imem_req && imem_ack) begin
                        instr_q <= imem_data;
                        state   <= S_HOLD;
                    end else if (timed_out) begin
                        instr_q <= '0;
                        state   <= S_HALT;
                    end
                end
                S_HOLD: begin
                    if (flush) begin
                        pc    <= in_ALU;
                        state <= en ? S_FETCH : S_IDLE;
                    end else if (instr_ready) begin
                        pc    <= S_MXPC ? pc_plus : in_ALU;
                        state <= en ? S_FETCH : S_IDLE;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit with a randomized memory/decode environment
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] in_ALU;
    logic        S_MXPC;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;
    bit rand_on  = 1'b0;

    logic [63:0] expq[$];
    logic [31:0] m_pc;

    pc_fetch_unit #(
        .ADDR_W(32),
        .RESET_PC(32'h0000_0000),
        .INC(1),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .in_ALU(in_ALU),
        .S_MXPC(S_MXPC),
        .flush(flush),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_data(imem_data),
        .instr_out(instr_out),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc(pc),
        .pc_plus(pc_plus),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every decode handshake must deliver the next expected (pc, instruction) pair
    always @(negedge clk) begin
        if (rand_on && instr_valid && instr_ready) begin
            if (expq.size() == 0) begin
                check("mon_underflow", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = expq.pop_front();
                check("mon_pc", {32'd0, pc}, {32'd0, e[63:32]});
                check("mon_instr", {32'd0, instr_out}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        int wait_cnt;
        rst_n = 1'b0; en = 1'b0; in_ALU = '0; S_MXPC = 1'b1; flush = 1'b0;
        imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b0;
        tick(); tick();
        check("rst_pc", {32'd0, pc}, 64'd0);
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_instr", {32'd0, instr_out}, 64'd0);
        check("rst_err", {63'd0, fetch_err}, 64'd0);

        // Randomized phase: memory answers with a known word per address, decode picks next PCs
        rst_n = 1'b1; en = 1'b1; m_pc = 32'h0; rand_on = 1'b1;
        wait_cnt = $urandom_range(0, 3);
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (imem_ack) begin
                imem_ack = 1'b0;
            end else if (imem_req) begin
                if (wait_cnt == 0) begin
                    check("rand_addr", {32'd0, imem_addr}, {32'd0, m_pc});
                    imem_data = mem_word(m_pc);
                    imem_ack  = 1'b1;
                    expq.push_back({m_pc, mem_word(m_pc)});
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                imem_ack  = 1'b1;
                imem_data = $urandom;
            end
            instr_ready = 1'($urandom_range(0, 1));
            S_MXPC      = 1'($urandom_range(0, 1));
            in_ALU      = $urandom;
            if (instr_valid && instr_ready) begin
                m_pc = S_MXPC ? m_pc + 32'd1 : in_ALU;
            end
            en = ($urandom_range(0, 7) != 0);
        end
        rand_on = 1'b0; instr_ready = 1'b0; imem_ack = 1'b0;
        check("rand_drain", {63'd0, expq.size() > 1}, 64'd0);

        // Directed: first fetch after reset
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; S_MXPC = 1'b1;
        tick(); tick();
        rst_n = 1'b1; en = 1'b1;
        tick();
        check("t1_req_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0});
        tick(); tick();
        imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
        check("t1_valid_at_ack", {63'd0, instr_valid}, 64'd0);
        tick();
        imem_ack = 1'b0;
        check("t1_instr", {31'd0, instr_valid, instr_out}, {31'd0, 1'b1, 32'hDEADBEEF});

        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_stall_data", {instr_out, pc}, {32'hDEADBEEF, 32'h0});
            check("t3_stall_hs", {62'd0, imem_req, instr_valid}, 64'd1);
        end

        instr_ready = 1'b1; S_MXPC = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t2_seq", {pc, imem_addr}, {32'h1, 32'h1});
        imem_ack = 1'b1; imem_data = 32'h12345678;
        tick();
        imem_ack = 1'b0;
        check("t2_instr", {32'd0, instr_out}, {32'd0, 32'h12345678});
        instr_ready = 1'b1; S_MXPC = 1'b0; in_ALU = 32'hFFFF0000;
        tick();
        instr_ready = 1'b0;
        check("t2_branch", {pc, imem_addr}, {32'hFFFF0000, 32'hFFFF0000});
        check("t2_req", {63'd0, imem_req}, 64'd1);

        flush = 1'b1; in_ALU = 32'h0000FFFF; imem_ack = 1'b1; imem_data = 32'h11112222;
        tick();
        flush = 1'b0; imem_ack = 1'b0;
        check("t4_gap", {30'd0, imem_req, instr_valid, pc}, {30'd0, 2'b00, 32'h0000FFFF});
        tick();
        check("t4_refetch", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0000FFFF});
        check("t4_instr_kept", {32'd0, instr_out}, {32'd0, 32'h12345678});

        flush = 1'b1; in_ALU = 32'hFFFFFFFF;
        tick();
        flush = 1'b0;
        tick();
        check("t5_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'hFFFFFFFF});
        check("t5_plus_wrap", {32'd0, pc_plus}, 64'd0);
        imem_ack = 1'b1; imem_data = 32'h0000A5A5;
        tick();
        imem_ack = 1'b0; instr_ready = 1'b1; S_MXPC = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t5_wrap", {pc, pc_plus}, {32'h0, 32'h1});

`ifdef FETCH_TIMEOUT_EN
        repeat (15) tick();
        check("t6_pre_timeout", {62'd0, imem_req, fetch_err}, 64'd2);
        tick();
        check("t6_timeout", {61'd0, imem_req, fetch_err, instr_valid}, 64'd2);
        imem_ack = 1'b1;
        repeat (3) tick();
        imem_ack = 1'b0;
        check("t6_halt", {61'd0, imem_req, fetch_err, instr_valid}, 64'd2);
`else
        repeat (20) tick();
        check("t6_no_timeout", {62'd0, imem_req, fetch_err}, 64'd2);
`endif

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b0; flush = 1'b1; in_ALU = 32'h5;
        tick();
        flush = 1'b0;
        check("t6_idle_flush", {31'd0, imem_req, pc}, {31'd0, 1'b0, 32'h5});
        check("t6_err_cleared", {63'd0, fetch_err}, 64'd0);
        en = 1'b1;
        tick();
        check("t6_fetch", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h5});
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_rst", {30'd0, imem_req, instr_valid, pc}, 64'd0);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
